// File: rtl/imem_loader_pkg.sv
// Shared types and frame field widths for the instruction-memory loader.
//   load_state_e : loader FSM states
//   is_loading() : true in the states that accept stream bytes
package imem_loader_pkg;

  localparam int unsigned LEN_W          = 16;  // frame word-count field
  localparam int unsigned BYTE_W         = 8;   // stream byte width
  localparam int unsigned WORD_W         = 32;  // instruction word width
  localparam int unsigned BYTE_IDX_W     = 2;   // byte position within a word

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    PAYLOAD,
    CSUM,
    DONE,
    ERR
  } load_state_e;

  function automatic logic is_loading(input load_state_e s);
    return (s == HDR0) || (s == HDR1) || (s == PAYLOAD) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction memory: one synchronous write port, one asynchronous read port,
// every word forced to RESET_WORD while rst is high.
//   clk, rst        : clock, async active-high reset
//   we/waddr/wdata  : write port, applied on the rising edge
//   raddr/rdata_c   : combinational read port
module imem_array
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter logic [31:0] RESET_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage with whole-array reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= RESET_WORD;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader that fills the instruction memory from a framed image
// (LEN_HI, LEN_LO, 4*N payload bytes, XOR checksum) and serves core fetches.
//   clk, rst           : clock, async active-high reset
//   in_valid/in_data   : stream byte; in_ready accepts it
//   pc / instruction   : core fetch port, combinational word read
//   cpu_rst            : holds the core in reset until the frame is accepted
//   load_done/error    : sticky frame result
//   words_loaded       : words written from the current frame
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter logic [31:0] RESET_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  input  logic [31:0]       pc,
  output logic [WORD_W-1:0] instruction,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  load_state_e             state_q, state_d;
  logic [BYTE_W-1:0]       len_hi_q, len_hi_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [WORD_W-9:0]       word_q, word_d;
  logic [BYTE_W-1:0]       csum_q, csum_d;
  logic [CNT_W-1:0]        words_q, words_d;
  logic                    ready_q, done_q, err_q, cpu_rst_q;

  logic                    xfer_c;
  logic [LEN_W-1:0]        len_c;
  logic                    we_c;
  logic [WORD_W-1:0]       wdata_c;
  logic                    pc_unused;

  assign xfer_c    = in_valid && ready_q;
  assign len_c     = {len_hi_q, in_data};
  assign pc_unused = ^{pc[31:ADDR_W+2], pc[1:0]};

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HDR0;
      len_hi_q   <= '0;
      len_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      words_q    <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      words_q    <= words_d;
      ready_q    <= is_loading(state_d);
      done_q     <= (state_d == DONE);
      err_q      <= (state_d == ERR);
      // Lags DONE by one edge so the core sees a fully settled memory
      cpu_rst_q  <= (state_q != DONE);
    end
  end

  // Next-state, frame parsing and write-port control
  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    words_d    = words_q;
    we_c       = 1'b0;
    wdata_c    = {word_q, in_data};

    case (state_q)
      HDR0: begin
        if (xfer_c) begin
          len_hi_d = in_data;
          state_d  = HDR1;
        end
      end
      HDR1: begin
        if (xfer_c) begin
          len_d = len_c;
          if (32'(len_c) > DEPTH) begin
            state_d = ERR;
          end else if (len_c == '0) begin
            state_d = CSUM;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (xfer_c) begin
          csum_d     = csum_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          word_d     = {word_q[WORD_W-17:0], in_data};
          // Fourth byte completes the word; write it on this same edge
          if (byte_idx_q == 2'd3) begin
            we_c    = 1'b1;
            words_d = words_q + CNT_W'(1);
            if (32'(words_q) + 32'd1 == 32'(len_q)) begin
              state_d = CSUM;
            end
          end
        end
      end
      CSUM: begin
        if (xfer_c) begin
          state_d = (in_data == csum_q) ? DONE : ERR;
        end
      end
      DONE: state_d = DONE;
      ERR:  state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  imem_array #(
    .ADDR_W     (ADDR_W),
    .RESET_WORD (RESET_WORD)
  ) u_imem_array (
    .clk     (clk),
    .rst     (rst),
    .we      (we_c),
    .waddr   (words_q[ADDR_W-1:0]),
    .wdata   (wdata_c),
    .raddr   (pc[ADDR_W+1:2]),
    .rdata_c (instruction)
  );

  assign in_ready     = ready_q;
  assign cpu_rst      = cpu_rst_q;
  assign load_done    = done_q;
  assign load_error   = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a frame-level model.
module tb_imem_loader;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DEPTH      = 1 << ADDR_W;
  localparam logic [31:0] RESET_WORD = 32'hA5A5_5A5A;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic [31:0]       pc = '0;
  logic [31:0]       instruction;
  logic              cpu_rst;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(
    .ADDR_W     (ADDR_W),
    .RESET_WORD (RESET_WORD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .pc           (pc),
    .instruction  (instruction),
    .cpu_rst      (cpu_rst),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Frame under test and the model's prediction for it
  logic [7:0]  frame[$];
  logic [31:0] exp_mem [DEPTH];
  bit          exp_done, exp_err;
  int          exp_wl, exp_used;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: parse header, unpack big-endian words, XOR check
  task automatic model_frame();
    int n;
    logic [7:0] x;
    for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = RESET_WORD;
    n        = (int'(frame[0]) << 8) | int'(frame[1]);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_wl   = 0;
    if (n > int'(DEPTH)) begin
      exp_err  = 1'b1;
      exp_used = 2;
      return;
    end
    x = '0;
    for (int w = 0; w < n; w++) begin
      exp_mem[w] = {frame[2+4*w], frame[3+4*w], frame[4+4*w], frame[5+4*w]};
      for (int k = 0; k < 4; k++) x ^= frame[2+4*w+k];
    end
    exp_wl   = n;
    exp_used = 3 + 4 * n;
    if (frame[2+4*n] == x) exp_done = 1'b1;
    else                   exp_err  = 1'b1;
  endtask

  task automatic build_frame(input int n, input bit corrupt);
    logic [7:0] x, b;
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    if (n > int'(DEPTH)) return;
    x = '0;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      x ^= b;
      frame.push_back(b);
    end
    frame.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready_first", 32'(in_ready), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_error", 32'(load_error), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    chk("rst_in_ready_after", 32'(in_ready), 32'd1);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    if (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap_mode, input int count);
    for (int i = 0; i < count; i++) begin
      case (gap_mode)
        0:       send_byte(frame[i], 1'b0);
        1:       send_byte(frame[i], 1'b1);
        default: send_byte(frame[i], 1'($urandom));
      endcase
    end
  endtask

  task automatic check_result(input string tag);
    @(negedge clk);
    chk({tag, "_done"}, 32'(load_done), 32'(exp_done));
    chk({tag, "_error"}, 32'(load_error), 32'(exp_err));
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_done));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'(exp_wl));
    for (int i = 0; i < int'(DEPTH); i++) begin
      pc = ($urandom() & ~32'h0000_03FC) | (32'(i) << 2);
      #0.1;
      chk({tag, "_mem"}, instruction, exp_mem[i]);
    end
    pc = '0;
  endtask

  // Bytes offered after the frame has finished must change nothing
  task automatic poke_ignored(input string tag);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_result(tag);
  endtask

  task automatic run_frame(input string tag, input int gap_mode);
    model_frame();
    do_reset();
    send_frame(gap_mode, exp_used);
    check_result(tag);
    poke_ignored({tag, "_after"});
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Directed reference image; checksum byte is the XOR of the payload
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
              8'h8C, 8'h09, 8'h00, 8'h04, 8'hAC};
    model_frame();
    do_reset();
    send_frame(0, exp_used);
    chk("t1_done_on_entry", 32'(load_done), 32'd1);
    chk("t1_cpu_rst_lags", 32'(cpu_rst), 32'd1);
    check_result("t1");
    pc = 32'h0;  #1 chk("t1_pc0", instruction, 32'h2008_0005);
    pc = 32'h4;  #1 chk("t1_pc4", instruction, 32'h8C09_0004);
    pc = 32'h405; #1 chk("t1_pc_wrap", instruction, 32'h8C09_0004);
    poke_ignored("t1_after");

    // Bad checksum
    frame[10] = 8'h80;
    run_frame("t2", 0);

    // Oversize header (257 words)
    frame = '{8'h01, 8'h01};
    run_frame("t3", 0);

    // Largest legal frame and an empty frame
    build_frame(int'(DEPTH), 1'b0);
    run_frame("full", 2);
    frame = '{8'h00, 8'h00, 8'h00};
    run_frame("t4", 0);

    // Valid toggling every cycle
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
              8'h8C, 8'h09, 8'h00, 8'h04, 8'hAC};
    run_frame("t5", 1);

    // Reset in the middle of the payload, then a full reload
    model_frame();
    do_reset();
    send_frame(0, 7);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t6_rst_words", 32'(words_loaded), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd0);
    chk("t6_rst_mem0", instruction, RESET_WORD);
    run_frame("t6", 0);

    // Randomized frames
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 9))
        0:       n = 0;
        1:       n = $urandom_range(int'(DEPTH) + 1, 65535);
        default: n = $urandom_range(1, 12);
      endcase
      build_frame(n, $urandom_range(0, 3) == 0);
      run_frame("rnd", $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
